// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage for a 256x32 instruction memory with a combinational read. The
// memory is byte addressed, and address bits [9:2] select the word. This
// block holds the program counter and drives IMAddress. It captures the
// returned word into the IF/ID register and offers that register to decode
// with a valid/ready handshake. Later stages can redirect fetch. Fetching a
// HALT_WORD parks the stage until a redirect or a reset.
//
// Ports
//   Clk            in   1       rising-edge clock
//   Reset          in   1       synchronous, active-high
//   IMAddress      out  ADDR_W  byte address to IM (truncated PC)
//   IMInstruction  in   32      combinational IM read data
//   BranchTaken    in   1       redirect request
//   BranchTarget   in   32      redirect byte address, bits [1:0] ignored
//   IDReady        in   1       decode accepts IF/ID this cycle
//   IFValid        out  1       IF/ID holds a valid instruction
//   InstructionOut out  32      IF/ID instruction
//   PCOut          out  32      PC of InstructionOut
//   PCPlus4Out     out  32      PCOut + 4 (mod 2^32)
//   Halted         out  1       fetch is parked in the HALTED state
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic [ADDR_W-1:0] IMAddress,
  input  logic [31:0]       IMInstruction,
  input  logic              BranchTaken,
  input  logic [31:0]       BranchTarget,
  input  logic              IDReady,
  output logic              IFValid,
  output logic [31:0]       InstructionOut,
  output logic [31:0]       PCOut,
  output logic [31:0]       PCPlus4Out,
  output logic              Halted
);

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetchState_t;

  fetchState_t r_state;
  fetchState_t w_nextState;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pcOut;
  logic [31:0] r_pcPlus4Out;
  logic        r_valid;

  logic        w_hold;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_target;
  logic        w_unusedTargetBits;

  // Decode has not taken the current instruction, so everything stays put.
  assign w_hold    = r_valid & ~IDReady;
  assign w_pcPlus4 = r_pc + 32'd4;
  assign w_target  = {BranchTarget[31:2], 2'b00};

  // The target's low bits are word-alignment noise and are dropped.
  assign w_unusedTargetBits = &{1'b0, BranchTarget[1:0]};

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A redirect always returns to FETCH, even when it
  // coincides with a halt-word fetch. A halt word seen while held is not
  // captured yet, so it cannot halt the stage until the hold clears.
  always_comb begin
    w_nextState = r_state;
    if (BranchTaken) begin
      w_nextState = FETCH;
    end else if (!w_hold && r_state == FETCH && IMInstruction == HALT_WORD) begin
      w_nextState = HALTED;
    end
  end

  // PC and IF/ID datapath. The priority is reset, then redirect, then hold,
  // then fetch. In HALTED, the PC stays frozen just past the halt word. Once
  // decode consumes the halt word, the valid bit drops and stays low.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc         <= RESET_PC;
      r_instr      <= 32'd0;
      r_pcOut      <= 32'd0;
      r_pcPlus4Out <= 32'd0;
      r_valid      <= 1'b0;
    end else if (BranchTaken) begin
      r_pc    <= w_target;
      r_instr <= 32'd0;
      r_valid <= 1'b0;
    end else if (w_hold) begin
      r_pc <= r_pc;
    end else if (r_state == FETCH) begin
      r_instr      <= IMInstruction;
      r_pcOut      <= r_pc;
      r_pcPlus4Out <= w_pcPlus4;
      r_valid      <= 1'b1;
      r_pc         <= w_pcPlus4;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign IMAddress      = r_pc[ADDR_W-1:0];
  assign IFValid        = r_valid;
  assign InstructionOut = r_instr;
  assign PCOut          = r_pcOut;
  assign PCPlus4Out     = r_pcPlus4Out;
  assign Halted         = (r_state == HALTED);

endmodule
